// File: rtl/descale_pkg.sv
// ----------------------------------------------------------------------------
// descale_pkg
// Shared types and helpers for the descale_shift unit.
//   - MODE_* : encodings of the 2-bit shift-mode field
//   - shift_mode_e : typed view of the same field
//   - sat_narrow : clamp a signed value to a signed out_w-bit range and
//                  report whether clamping changed it
// ----------------------------------------------------------------------------
package descale_pkg;

   localparam logic [1:0] MODE_SRA = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_RND = 2'b10;
   localparam logic [1:0] MODE_SLL = 2'b11;

   typedef enum logic [1:0] {
      SRA = MODE_SRA,
      SRL = MODE_SRL,
      RND = MODE_RND,
      SLL = MODE_SLL
   } shift_mode_e;

   // Works on a 64-bit signed carrier so one function serves every DATA_W/OUT_W
   // combination up to 64 bits.
   function automatic logic signed [63:0] sat_narrow(
      input  logic signed [63:0] r,
      input  int                 out_w,
      output logic               ovf
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      ovf = 1'b0;
      sat_narrow = r;
      if (r > hi) begin
         sat_narrow = hi;
         ovf        = 1'b1;
      end else if (r < lo) begin
         sat_narrow = lo;
         ovf        = 1'b1;
      end
   endfunction

endpackage

// File: rtl/descale_shift_core.sv
// ----------------------------------------------------------------------------
// descale_shift_core
// Combinational shifter and narrower. Produces the DATA_W-bit intermediate r
// for the selected mode, then narrows it to OUT_W bits.
// Optional feature macro: DESCALE_SAT_EN (saturating narrow + ovf flag);
// when undefined the result is truncated and o_ovf is tied low.
// Ports:
//   i_data     signed operand
//   i_shamt    unsigned shift amount (values >= DATA_W are legal)
//   i_mode     shift mode
//   i_rnd_sum  operand + rounding addend, DATA_W+1 bits (precomputed in S1)
//   o_data     narrowed result
//   o_ovf      1 when saturation changed the value
// ----------------------------------------------------------------------------
module descale_shift_core
   import descale_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int OUT_W   = 8,
   parameter int SHAMT_W = 5
) (
   input  logic [DATA_W-1:0]  i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
   input  shift_mode_e        i_mode,
   input  logic [DATA_W:0]    i_rnd_sum,
   output logic [OUT_W-1:0]   o_data,
   output logic               o_ovf
);

   logic                     w_big;
   logic signed [DATA_W-1:0] w_sra;
   logic signed [DATA_W:0]   w_rnd_shift;
   logic [DATA_W-1:0]        w_r;
   logic                     w_unused_rnd;

   assign w_big = 32'(i_shamt) >= 32'(DATA_W);

   // Kept as separate signed signals: inside a ternary with unsigned operands
   // the arithmetic shift would silently degrade to a logical one.
   assign w_sra       = $signed(i_data) >>> i_shamt;
   assign w_rnd_shift = $signed(i_rnd_sum) >>> i_shamt;

   // The sum cannot wrap at DATA_W+1 bits, so after any shift n >= 1 the top
   // bit equals bit DATA_W-1 and can be dropped.
   assign w_unused_rnd = w_rnd_shift[DATA_W];

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // w_r unassigned, which would otherwise infer a latch.
      w_r = '0;
      case (i_mode)
         SRA: w_r = w_big ? {DATA_W{i_data[DATA_W-1]}} : w_sra;
         SRL: w_r = w_big ? '0 : (i_data >> i_shamt);
         RND: begin
            if (i_shamt == '0)
               w_r = i_data;
            else if (w_big)
               w_r = '0;
            else
               w_r = w_rnd_shift[DATA_W-1:0];
         end
         SLL: w_r = w_big ? '0 : (i_data << i_shamt);
         default: w_r = '0;
      endcase
   end

`ifdef DESCALE_SAT_EN
   logic signed [63:0] w_sat;
   logic               w_sat_ovf;
   logic               w_unused_sat_hi;

   always_comb begin
      w_sat_ovf = 1'b0;
      w_sat     = sat_narrow(64'($signed(w_r)), OUT_W, w_sat_ovf);
   end

   assign o_data          = w_sat[OUT_W-1:0];
   assign o_ovf           = w_sat_ovf;
   assign w_unused_sat_hi = ^w_sat[63:OUT_W];
`else
   assign o_data = w_r[OUT_W-1:0];
   assign o_ovf  = 1'b0;

   generate
      if (OUT_W < DATA_W) begin : g_trunc_hi
         logic w_unused_trunc_hi;
         assign w_unused_trunc_hi = ^w_r[DATA_W-1:OUT_W];
      end
   endgenerate
`endif

endmodule

// File: rtl/descale_shift.sv
// ----------------------------------------------------------------------------
// descale_shift
// Two-stage valid/ready shift/descale pipeline. S1 captures the operand,
// mode, amount, tag and the rounding sum; S2 captures the shifted and
// narrowed result from descale_shift_core plus the overflow flag.
// Optional feature macro: DESCALE_SAT_EN (see descale_shift_core).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_data, in_shamt   operand and shift amount
//   in_mode             00 SRA, 01 SRL, 10 RND, 11 SLL
//   in_tag              sideband, passed through unchanged
//   out_valid/out_ready output handshake
//   out_data, out_tag   result and its sideband
//   out_ovf             result was saturated on this beat
// ----------------------------------------------------------------------------
module descale_shift
   import descale_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int OUT_W   = 8,
   parameter int SHAMT_W = 5,
   parameter int TAG_W   = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_ovf
);

   localparam logic [DATA_W:0]  SUM_ONE   = 1;
   localparam logic [SHAMT_W-1:0] SHAMT_ONE = 1;

   // S1 registers
   logic               r_s1_valid;
   logic [DATA_W-1:0]  r_s1_data;
   logic [SHAMT_W-1:0] r_s1_shamt;
   shift_mode_e        r_s1_mode;
   logic [TAG_W-1:0]   r_s1_tag;
   logic [DATA_W:0]    r_s1_sum;

   // S2 registers
   logic               r_s2_valid;
   logic [OUT_W-1:0]   r_s2_data;
   logic [TAG_W-1:0]   r_s2_tag;
   logic               r_s2_ovf;

   logic               w_s2_free;
   logic               w_s1_free;
   logic               w_accept;
   logic [DATA_W:0]    w_addend;
   logic [DATA_W:0]    w_sum;
   logic [OUT_W-1:0]   w_core_data;
   logic               w_core_ovf;

   // A slot can take a new beat when it is empty or its content leaves now.
   assign w_s2_free = !r_s2_valid || out_ready;
   assign w_s1_free = !r_s1_valid || w_s2_free;
   assign in_ready  = w_s1_free;
   assign w_accept  = in_valid && w_s1_free;

   // Rounding addend 2^(n-1); the sign-extended sum at DATA_W+1 bits never
   // wraps, even for the most positive operand.
   assign w_addend = (in_shamt == '0) ? '0 : (SUM_ONE << (in_shamt - SHAMT_ONE));
   assign w_sum    = {in_data[DATA_W-1], in_data} + w_addend;

   // NOTE: the datapath registers are reset too, so out_data/out_tag read as
   // zero after reset rather than whatever the flops powered up with.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_shamt <= '0;
         r_s1_mode  <= SRA;
         r_s1_tag   <= '0;
         r_s1_sum   <= '0;
      end else if (w_s1_free) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_data  <= in_data;
            r_s1_shamt <= in_shamt;
            r_s1_mode  <= shift_mode_e'(in_mode);
            r_s1_tag   <= in_tag;
            r_s1_sum   <= w_sum;
         end
      end
   end

   descale_shift_core #(
      .DATA_W  (DATA_W),
      .OUT_W   (OUT_W),
      .SHAMT_W (SHAMT_W)
   ) u_core (
      .i_data    (r_s1_data),
      .i_shamt   (r_s1_shamt),
      .i_mode    (r_s1_mode),
      .i_rnd_sum (r_s1_sum),
      .o_data    (w_core_data),
      .o_ovf     (w_core_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_tag   <= '0;
         r_s2_ovf   <= 1'b0;
      end else if (w_s2_free) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data <= w_core_data;
            r_s2_tag  <= r_s1_tag;
            r_s2_ovf  <= w_core_ovf;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_data  = r_s2_data;
   assign out_tag   = r_s2_tag;
   assign out_ovf   = r_s2_ovf;

   // Shift mode is only consumed through S1; w_accept documents the transfer
   // condition and is folded here to keep it referenced.
   logic w_unused_accept;
   assign w_unused_accept = w_accept;

endmodule

// File: tb/tb_descale_shift.sv
// ----------------------------------------------------------------------------
// tb_descale_shift
// Directed bench for descale_shift at DATA_W=16, OUT_W=8. Expected values are
// hand-derived; the saturating variants apply when DESCALE_SAT_EN is defined.
// ----------------------------------------------------------------------------
module tb_descale_shift;

   localparam int DATA_W  = 16;
   localparam int OUT_W   = 8;
   localparam int SHAMT_W = 5;
   localparam int TAG_W   = 6;
`ifdef DESCALE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam logic [1:0] M_SRA = 2'b00;
   localparam logic [1:0] M_SRL = 2'b01;
   localparam logic [1:0] M_RND = 2'b10;
   localparam logic [1:0] M_SLL = 2'b11;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic [1:0]         in_mode;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   out_data;
   logic [TAG_W-1:0]   out_tag;
   logic               out_ovf;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   descale_shift #(
      .DATA_W  (DATA_W),
      .OUT_W   (OUT_W),
      .SHAMT_W (SHAMT_W),
      .TAG_W   (TAG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_ovf   (out_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Call at a falling edge with an idle pipeline and out_ready = 1.
   task automatic apply(input string tag, input logic [1:0] mode, input logic [15:0] x,
                        input logic [4:0] n, input logic [5:0] t,
                        input logic [7:0] exp_d, input logic exp_o);
      int lat;
      in_valid = 1'b1;
      in_mode  = mode;
      in_data  = x;
      in_shamt = n;
      in_tag   = t;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 8);
      check({tag, ".latency"}, lat, 2);
      check({tag, ".data"}, out_data, exp_d);
      check({tag, ".ovf"}, out_ovf, exp_o);
      check({tag, ".tag"}, out_tag, t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic             acc;
      logic             held;
      logic             ir_checked;
      logic             seen_stale;
      logic [OUT_W-1:0] h_data;
      logic [TAG_W-1:0] h_tag;
      int               sent;
      int               rx;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_mode   = M_SRA;
      in_tag    = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset.out_valid", out_valid, 0);
      check("reset.out_data", out_data, 0);
      check("reset.out_tag", out_tag, 0);
      check("reset.out_ovf", out_ovf, 0);
      rst_n = 1'b1;
      #1;
      check("reset.in_ready", in_ready, 1);
      @(negedge clk);

      // Mode vectors
      apply("sra_ff80_3",  M_SRA, 16'hFF80, 5'd3,  6'd1,  8'hF0, 1'b0);
      apply("srl_ff80_3",  M_SRL, 16'hFF80, 5'd3,  6'd2,  SAT ? 8'h7F : 8'hF0, SAT);
      apply("rnd_m5_1",    M_RND, 16'hFFFB, 5'd1,  6'd3,  8'hFE, 1'b0);
      apply("rnd_5_1",     M_RND, 16'h0005, 5'd1,  6'd4,  8'h03, 1'b0);
      apply("rnd_7fff_8",  M_RND, 16'h7FFF, 5'd8,  6'd5,  SAT ? 8'h7F : 8'h80, SAT);
      apply("rnd_n0",      M_RND, 16'h0042, 5'd0,  6'd6,  8'h42, 1'b0);
      apply("sra_1234_2",  M_SRA, 16'h1234, 5'd2,  6'd7,  SAT ? 8'h7F : 8'h8D, SAT);
      apply("sll_3_4",     M_SLL, 16'h0003, 5'd4,  6'd8,  8'h30, 1'b0);
      // Oversized and edge amounts
      apply("sra_8000_20", M_SRA, 16'h8000, 5'd20, 6'd9,  8'hFF, 1'b0);
      apply("srl_8000_20", M_SRL, 16'h8000, 5'd20, 6'd10, 8'h00, 1'b0);
      apply("rnd_8000_20", M_RND, 16'h8000, 5'd20, 6'd11, 8'h00, 1'b0);
      apply("sll_8000_20", M_SLL, 16'h8000, 5'd20, 6'd12, 8'h00, 1'b0);
      apply("sra_1234_16", M_SRA, 16'h1234, 5'd16, 6'd13, 8'h00, 1'b0);
      apply("srl_8000_15", M_SRL, 16'h8000, 5'd15, 6'd14, 8'h01, 1'b0);
      apply("sll_1_15",    M_SLL, 16'h0001, 5'd15, 6'd15, SAT ? 8'h80 : 8'h00, SAT);

      // Drain the last beat before backpressure starts
      @(negedge clk);

      // Backpressure: 6 beats, out_ready low for the first 4 cycles
      sent       = 0;
      rx         = 0;
      held       = 1'b0;
      ir_checked = 1'b0;
      h_data     = '0;
      h_tag      = '0;
      for (int k = 0; k < 40 && rx < 6; k++) begin
         out_ready = (k >= 4);
         #1;
         if (sent == 2 && !out_ready && !ir_checked) begin
            check("bp.in_ready_drop", in_ready, 0);
            ir_checked = 1'b1;
         end
         if (out_valid) begin
            if (held) begin
               check("bp.hold_data", out_data, h_data);
               check("bp.hold_tag", out_tag, h_tag);
            end
            if (out_ready) begin
               check("bp.order_tag", out_tag, 32'(10 + rx));
               check("bp.order_data", out_data, 32'(8'h20 + 2 * rx));
               rx++;
               held = 1'b0;
            end else begin
               held   = 1'b1;
               h_data = out_data;
               h_tag  = out_tag;
            end
         end
         if (sent < 6) begin
            in_valid = 1'b1;
            in_mode  = M_SLL;
            in_shamt = 5'd1;
            in_data  = 16'(16'h0010 + sent);
            in_tag   = 6'(10 + sent);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) sent++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("bp.ir_checked", ir_checked, 1);
      check("bp.sent", sent, 6);
      check("bp.received", rx, 6);
      #1;
      check("bp.drained", out_valid, 0);

      // Reset mid-stream with two beats in flight
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_mode = M_SRA; in_shamt = 5'd0; in_data = 16'h0011; in_tag = 6'd40;
      @(posedge clk);
      @(negedge clk);
      in_data = 16'h0022; in_tag = 6'd41;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("rst.pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rst.out_valid_async", out_valid, 0);
      check("rst.out_tag", out_tag, 0);
      check("rst.in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      seen_stale = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) seen_stale = 1'b1;
      end
      check("rst.no_stale", seen_stale, 0);
      check("rst.in_ready_after", in_ready, 1);

      // Pipeline still usable after reset
      apply("post_rst_sra", M_SRA, 16'hFF80, 5'd3, 6'd42, 8'hF0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
